// File: rtl/aes_pkg.sv
// Shared AES helpers: FSM encoding, round-constant seed, xtime and a computed S-box.
package aes_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StExpand,
        StFinish
    } state_e;

    localparam logic [7:0] RconInit = 8'h01;

    // Multiply by x in GF(2^8); 8'h80 wraps to 8'h1b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                p = p ^ x;
            end
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as x^254 through a fixed square-and-multiply chain; maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    // Forward S-box: field inverse followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

endpackage

// File: rtl/sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] result
);

    assign result = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/key_expand_seq.sv
// Sequential AES key schedule: one 32-bit schedule word per clock, one shared SubWord path.
module key_expand_seq
    import aes_pkg::*;
#(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = Nk + 6
) (
    input  logic                    clks,
    input  logic                    reset,
    input  logic                    start,
    input  logic [0:32*Nk-1]        key_in,
    output logic                    busy,
    output logic                    done,
    output logic [0:128*(Nr+1)-1]   keys
);

    localparam int unsigned NumWords = 4 * (Nr + 1);
    localparam int unsigned IdxW     = $clog2(NumWords + 1);
    localparam int unsigned ModW     = $clog2(Nk);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [ModW-1:0]   mod_q, mod_d;
    logic [7:0]        rcon_q, rcon_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load, step;

    // Sliding window of the last Nk words: [0] is w[i-Nk], [Nk-1] is w[i-1].
    logic [31:0]             win_q [Nk];
    logic [0:128*(Nr+1)-1]   keys_q;

    logic [31:0] prev_word, sub_in, sub_out, temp, new_word, wr_base;
    logic        mod_zero, mod_four;

    assign mod_zero  = (mod_q == '0);
    assign mod_four  = (Nk == 8) && (32'(mod_q) == 32'd4);
    assign prev_word = win_q[Nk-1];
    assign sub_in    = mod_zero ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    assign wr_base   = 32'(idx_q) << 5;

    sub_word u_sub_word (
        .word   (sub_in),
        .result (sub_out)
    );

    // Schedule recurrence for the word at index idx_q.
    always_comb begin
        temp = prev_word;
        if (mod_zero) begin
            temp = sub_out ^ {rcon_q, 24'h000000};
        end else if (mod_four) begin
            temp = sub_out;
        end
        new_word = win_q[0] ^ temp;
    end

    // Next-state and control decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mod_d   = mod_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    idx_d   = IdxW'(Nk);
                    mod_d   = '0;
                    rcon_d  = RconInit;
                    busy_d  = 1'b1;
                    state_d = StExpand;
                end
            end
            StExpand: begin
                step  = 1'b1;
                idx_d = idx_q + 1'b1;
                mod_d = (mod_q == ModW'(Nk - 1)) ? '0 : mod_q + 1'b1;
                if (mod_zero) begin
                    rcon_d = xtime(rcon_q);
                end
                if (idx_q == IdxW'(NumWords - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clks) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            mod_q   <= '0;
            rcon_q  <= RconInit;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mod_q   <= mod_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Round-key bus and word window: key load on start, then one word per expand edge.
    always_ff @(posedge clks) begin
        if (reset) begin
            keys_q <= '0;
            for (int k = 0; k < Nk; k++) begin
                win_q[k] <= '0;
            end
        end else if (load) begin
            keys_q[0 +: 32*Nk] <= key_in;
            for (int k = 0; k < Nk; k++) begin
                win_q[k] <= key_in[32*k +: 32];
            end
        end else if (step) begin
            keys_q[wr_base +: 32] <= new_word;
            for (int k = 0; k < Nk - 1; k++) begin
                win_q[k] <= win_q[k+1];
            end
            win_q[Nk-1] <= new_word;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign keys = keys_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// Directed bench for key_expand_seq using FIPS-197 key-expansion vectors for Nk = 4, 6, 8.
module tb_key_expand_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start4, start6, start8;
    logic [0:127] key4;
    logic [0:191] key6;
    logic [0:255] key8;
    logic busy4, busy6, busy8;
    logic done4, done6, done8;
    logic [0:1407] keys4;
    logic [0:1663] keys6;
    logic [0:1919] keys8;

    int checks = 0;
    int errors = 0;

    localparam logic [0:127] K1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] K1R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] K0R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_expand_seq #(.Nk(4)) dut4 (
        .clks(clk), .reset(reset), .start(start4), .key_in(key4),
        .busy(busy4), .done(done4), .keys(keys4)
    );
    key_expand_seq #(.Nk(6)) dut6 (
        .clks(clk), .reset(reset), .start(start6), .key_in(key6),
        .busy(busy6), .done(done6), .keys(keys6)
    );
    key_expand_seq #(.Nk(8)) dut8 (
        .clks(clk), .reset(reset), .start(start8), .key_in(key8),
        .busy(busy8), .done(done8), .keys(keys8)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges after the start edge until done4 rises; start4 is left alone.
    task automatic wait_done4(output int edges);
        edges = 0;
        while (!done4 && edges < 200) begin
            tick();
            edges++;
        end
    endtask

    // One Nk=4 run; optional extra start pulse on edge pulse_at, key changed after sampling.
    task automatic run4(input logic [0:127] key, input int pulse_at, output int edges);
        key4   = key;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        key4   = ~key;
        check("busy after start", 128'(busy4), 128'd1);
        edges = 0;
        while (!done4 && edges < 200) begin
            start4 = (pulse_at != 0) && (edges + 1 == pulse_at);
            tick();
            edges++;
        end
        start4 = 1'b0;
    endtask

    initial begin
        int edges;
        reset  = 1'b1;
        start4 = 1'b0;
        start6 = 1'b0;
        start8 = 1'b0;
        key4   = '0;
        key6   = '0;
        key8   = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy", 128'(busy4), 128'd0);
        check("reset done", 128'(done4), 128'd0);
        check("reset keys", 128'(|keys4), 128'd0);

        // Vector 1: AES-128.
        run4(K1, 0, edges);
        check("nk4 latency", 128'(edges), 128'd40);
        check("nk4 busy at done", 128'(busy4), 128'd0);
        check("nk4 round0", keys4[0 +: 128], K1);
        check("nk4 w4", 128'(keys4[128 +: 32]), 128'ha0fafe17);
        check("nk4 round10", keys4[1280 +: 128], K1R10);
        tick();
        check("nk4 done one cycle", 128'(done4), 128'd0);
        tick();
        tick();
        check("nk4 hold in idle", keys4[1280 +: 128], K1R10);

        // Vector 2: AES-192.
        key6   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        edges  = 0;
        while (!done6 && edges < 200) begin
            tick();
            edges++;
        end
        check("nk6 latency", 128'(edges), 128'd46);
        check("nk6 round12", keys6[1536 +: 128], 128'he98ba06f448c773c8ecc720401002202);

        // Vector 3: AES-256, includes the i mod 8 == 4 SubWord.
        key8   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        edges  = 0;
        while (!done8 && edges < 200) begin
            tick();
            edges++;
        end
        check("nk8 latency", 128'(edges), 128'd52);
        check("nk8 w12", 128'(keys8[384 +: 32]), 128'ha8b09c1a);
        check("nk8 round14", keys8[1792 +: 128], 128'hfe4890d1e6188d0b046df344706c631e);
        tick();
        tick();

        // Reset at edge 20 of an Nk=4 run.
        key4   = 128'h00112233445566778899aabbccddeeff;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 19; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrun reset keys", 128'(|keys4), 128'd0);
        check("midrun reset busy", 128'(busy4), 128'd0);
        check("midrun reset done", 128'(done4), 128'd0);
        run4(K1, 0, edges);
        check("after reset latency", 128'(edges), 128'd40);
        check("after reset round10", keys4[1280 +: 128], K1R10);
        tick();
        tick();

        // Start pulsed at edge 10 while busy must be ignored.
        run4(K1, 10, edges);
        check("ignored start latency", 128'(edges), 128'd40);
        check("ignored start round10", keys4[1280 +: 128], K1R10);
        check("ignored start w4", 128'(keys4[128 +: 32]), 128'ha0fafe17);
        tick();
        tick();

        // Back-to-back: start held high across K1 then the all-zero key.
        key4   = K1;
        start4 = 1'b1;
        tick();
        wait_done4(edges);
        check("b2b first latency", 128'(edges), 128'd40);
        check("b2b first round10", keys4[1280 +: 128], K1R10);
        tick();
        check("b2b idle done", 128'(done4), 128'd0);
        check("b2b idle busy", 128'(busy4), 128'd0);
        check("b2b idle hold", keys4[1280 +: 128], K1R10);
        key4 = '0;
        tick();
        check("b2b restart busy", 128'(busy4), 128'd1);
        wait_done4(edges);
        start4 = 1'b0;
        check("b2b second latency", 128'(edges), 128'd40);
        check("b2b second w4", 128'(keys4[128 +: 32]), 128'h62636363);
        check("b2b second round10", keys4[1280 +: 128], K0R10);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
